// File: rtl/sha256_round_sequencer_pkg.sv
// Shared state encoding and SHA-256 sizing constants for the round sequencer.
package sha256_ctrl_pkg;

   localparam int SHA_ROUNDS    = 64;
   localparam int SHA_MSG_WORDS = 16;
   localparam int SHA_RIDX_W    = 6;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ROUND = 3'd2,
      FINAL = 3'd3,
      NEXT  = 3'd4,
      DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/sha256_round_sequencer_if.sv
// Block handshake between the message buffer (master) and the round sequencer (slave).
interface sha256_round_sequencer_if;

   logic blk_valid;
   logic blk_first;
   logic blk_last;
   logic blk_ready;
   logic abort;

   modport master (output blk_valid, output blk_first, output blk_last, output abort,
                   input  blk_ready);
   modport slave  (input  blk_valid, input  blk_first, input  blk_last, input  abort,
                   output blk_ready);

endinterface

// File: rtl/sha256_round_sequencer_phase_ctr.sv
// Position-within-round counter; o_last strobes on the final phase and commits the round.
module sha256_phase_ctr #(
   parameter int CPR = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clr,
   input  logic       i_en,
   output logic [1:0] o_phase,
   output logic       o_last
);

   logic [1:0] r_phase;
   logic       w_at_last;

   assign w_at_last = (r_phase == 2'(CPR - 1));

   // Phase register: wraps after CPR-1 so the next round starts at phase 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase <= 2'd0;
      end else if (i_clr) begin
         r_phase <= 2'd0;
      end else if (i_en) begin
         r_phase <= w_at_last ? 2'd0 : r_phase + 2'd1;
      end else begin
         r_phase <= r_phase;
      end
   end

   assign o_phase = r_phase;
   assign o_last  = i_en & w_at_last;

endmodule

// File: rtl/sha256_round_sequencer.sv
// SHA-256 compression control FSM: block load, 64 rounds, digest feed-forward, done pulse.
// Optional SHA_PERF_CNT_EN adds saturating block and busy-cycle counters.
module sha256_round_sequencer
   import sha256_ctrl_pkg::*;
#(
   parameter int CYCLES_PER_ROUND = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   sha256_round_sequencer_if.slave  blk_bus,
   output logic                     o_init_load,
   output logic                     o_iv_sel,
   output logic [SHA_RIDX_W-1:0]    o_round_idx,
   output logic [1:0]               o_phase,
   output logic                     o_w_from_msg,
   output logic                     o_round_en,
   output logic                     o_digest_upd,
   output logic                     o_busy,
   output logic                     o_done
`ifdef SHA_PERF_CNT_EN
   ,
   output logic [31:0]              o_blk_count,
   output logic [31:0]              o_cyc_count
`endif
);

   state_e                r_state;
   state_e                w_state_seq;
   state_e                w_state_nxt;
   logic                  r_first;
   logic                  r_last;
   logic [SHA_RIDX_W-1:0] r_round_idx;
   logic                  w_ready;
   logic                  w_accept;
   logic                  w_in_round;
   logic                  w_round_en;
   logic                  w_init_load;
   logic                  w_iv_sel;
   logic                  w_digest_upd;
   logic                  w_done;

   assign w_in_round = (r_state == ROUND);
   assign w_ready    = (r_state == IDLE) | (r_state == NEXT);
   // Abort beats a same-cycle handshake so a dropped message cannot restart.
   assign w_accept   = blk_bus.blk_valid & w_ready & ~blk_bus.abort;

   sha256_phase_ctr #(.CPR(CYCLES_PER_ROUND)) u_phase_ctr (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (~w_in_round | blk_bus.abort),
      .i_en    (w_in_round),
      .o_phase (o_phase),
      .o_last  (w_round_en)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Block sideband is latched on accept and held for the whole block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_first <= 1'b0;
         r_last  <= 1'b0;
      end else if (w_accept) begin
         r_first <= blk_bus.blk_first;
         r_last  <= blk_bus.blk_last;
      end else begin
         r_first <= r_first;
         r_last  <= r_last;
      end
   end

   // Round index: zeroed in LOAD, wraps to 0 naturally on the round-63 commit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_round_idx <= {SHA_RIDX_W{1'b0}};
      end else if (blk_bus.abort || (r_state == LOAD)) begin
         r_round_idx <= {SHA_RIDX_W{1'b0}};
      end else if (w_round_en) begin
         r_round_idx <= r_round_idx + SHA_RIDX_W'(1);
      end else begin
         r_round_idx <= r_round_idx;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      w_state_seq  = r_state;
      w_init_load  = 1'b0;
      w_iv_sel     = 1'b0;
      w_digest_upd = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE, NEXT: begin
            if (w_accept) begin
               w_state_seq = LOAD;
            end else begin
               w_state_seq = r_state;
            end
         end
         LOAD: begin
            w_init_load = 1'b1;
            w_iv_sel    = r_first;
            w_state_seq = ROUND;
         end
         ROUND: begin
            if (w_round_en && (r_round_idx == SHA_RIDX_W'(SHA_ROUNDS - 1))) begin
               w_state_seq = FINAL;
            end else begin
               w_state_seq = ROUND;
            end
         end
         FINAL: begin
            w_digest_upd = ~blk_bus.abort;
            w_state_seq  = r_last ? DONE : NEXT;
         end
         DONE: begin
            w_done      = ~blk_bus.abort;
            w_state_seq = IDLE;
         end
         default: begin
            w_state_seq = IDLE;
         end
      endcase
      if (blk_bus.abort) begin
         w_state_nxt = IDLE;
      end else begin
         w_state_nxt = w_state_seq;
      end
   end

   assign blk_bus.blk_ready = w_ready;
   assign o_init_load       = w_init_load;
   assign o_iv_sel          = w_iv_sel;
   assign o_round_idx       = r_round_idx;
   assign o_w_from_msg      = w_in_round & (r_round_idx < SHA_RIDX_W'(SHA_MSG_WORDS));
   assign o_round_en        = w_round_en;
   assign o_digest_upd      = w_digest_upd;
   assign o_busy            = (r_state != IDLE);
   assign o_done            = w_done;

`ifdef SHA_PERF_CNT_EN
   logic [31:0] r_blk_count;
   logic [31:0] r_cyc_count;

   // Saturating counters; deliberately untouched by abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blk_count <= 32'd0;
         r_cyc_count <= 32'd0;
      end else begin
         if (w_digest_upd && (r_blk_count != 32'hFFFF_FFFF)) begin
            r_blk_count <= r_blk_count + 32'd1;
         end else begin
            r_blk_count <= r_blk_count;
         end
         if (o_busy && (r_cyc_count != 32'hFFFF_FFFF)) begin
            r_cyc_count <= r_cyc_count + 32'd1;
         end else begin
            r_cyc_count <= r_cyc_count;
         end
      end
   end

   assign o_blk_count = r_blk_count;
   assign o_cyc_count = r_cyc_count;
`endif

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Scoreboard bench: stimulus predicts event timing from the block-level schedule, a monitor
// pops and compares; a behavioural SHA-256 datapath driven by the DUT strobes checks "abc".
module tb_sha256_round_sequencer;

   localparam int CPR = 3;
   localparam int RUN = 64 * CPR;
   localparam int BIG = 32'h7fff_ffff;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sha256_round_sequencer_if bus ();
   logic       init_load, iv_sel, w_from_msg, round_en, digest_upd, busy, done;
   logic [5:0] round_idx;
   logic [1:0] phase;
`ifdef SHA_PERF_CNT_EN
   logic [31:0] blk_count, cyc_count;
`endif

   sha256_round_sequencer #(.CYCLES_PER_ROUND(CPR)) dut (
      .clk(clk), .rst(rst), .blk_bus(bus),
      .o_init_load(init_load), .o_iv_sel(iv_sel), .o_round_idx(round_idx), .o_phase(phase),
      .o_w_from_msg(w_from_msg), .o_round_en(round_en), .o_digest_upd(digest_upd),
      .o_busy(busy), .o_done(done)
`ifdef SHA_PERF_CNT_EN
      , .o_blk_count(blk_count), .o_cyc_count(cyc_count)
`endif
   );

   // kind: 0 init_load (aux=iv_sel), 1 round_en (aux=round), 2 digest_upd, 3 done (aux=abc)
   typedef struct { int kind; int cyc; int aux; } ev_t;
   ev_t exp_q[$];
   ev_t mon_e;
   int  mon_k;

   int cyc = 0;
   int checks = 0, failures = 0;
   int nr_start = 0, ready_at = 0, busy_start = 0, busy_end = 0;
   int exp_blk = 0, exp_cyc = 0, last_accept = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   logic [31:0] ABC_H [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                              32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
   logic [31:0] H [8], wk [8], W [64], msg [16];
   logic [31:0] t1, t2;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Behavioural datapath obeying the sequencer strobes.
   always @(posedge clk) begin
      if (init_load) begin
         for (int i = 0; i < 8; i++) begin
            if (iv_sel) H[i] = IV[i];
            wk[i] = H[i];
         end
         for (int t = 0; t < 64; t++) begin
            if (t < 16) W[t] = msg[t];
            else W[t] = (rotr(W[t-2], 17) ^ rotr(W[t-2], 19) ^ (W[t-2] >> 10)) + W[t-7]
                      + (rotr(W[t-15], 7) ^ rotr(W[t-15], 18) ^ (W[t-15] >> 3)) + W[t-16];
         end
      end else if (round_en) begin
         t1 = wk[7] + (rotr(wk[4], 6) ^ rotr(wk[4], 11) ^ rotr(wk[4], 25))
            + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[round_idx] + W[round_idx];
         t2 = (rotr(wk[0], 2) ^ rotr(wk[0], 13) ^ rotr(wk[0], 22))
            + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
         for (int i = 7; i > 0; i--) wk[i] = wk[i-1];
         wk[4] = wk[4] + t1;
         wk[0] = t1 + t2;
      end else if (digest_upd) begin
         for (int i = 0; i < 8; i++) H[i] = H[i] + wk[i];
      end
   end

   // Monitor: level checks every cycle, event pops whenever a strobe appears.
   always @(negedge clk) begin
      if (!rst) begin
         chk("blk_ready", bus.blk_ready, !((cyc >= nr_start) && (cyc < ready_at)));
         chk("busy", busy, (cyc >= busy_start) && (cyc < busy_end));
         if ((cyc >= busy_start) && (cyc < busy_end)) exp_cyc++;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_event: kind %0d due cycle %0d not seen by cycle %0d",
                     exp_q[0].kind, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
         end
         mon_k = init_load ? 0 : round_en ? 1 : digest_upd ? 2 : done ? 3 : -1;
         if (mon_k >= 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", mon_k, -1);
            end else begin
               mon_e = exp_q.pop_front();
               chk("event_kind", mon_k, mon_e.kind);
               chk("event_cycle", cyc, mon_e.cyc);
               if (mon_e.kind == 0) chk("iv_sel", iv_sel, mon_e.aux);
               if (mon_e.kind == 1) begin
                  chk("round_idx", round_idx, mon_e.aux);
                  chk("phase_at_commit", phase, CPR - 1);
                  chk("w_from_msg", w_from_msg, mon_e.aux < 16);
               end
               if (mon_e.kind == 3 && mon_e.aux == 1) begin
                  for (int i = 0; i < 8; i++) chk("abc_digest", H[i], ABC_H[i]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_blk_ready", bus.blk_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_init_load", init_load, 0);
      chk("rst_iv_sel", iv_sel, 0);
      chk("rst_round_idx", round_idx, 0);
      chk("rst_phase", phase, 0);
      chk("rst_w_from_msg", w_from_msg, 0);
      chk("rst_round_en", round_en, 0);
      chk("rst_digest_upd", digest_upd, 0);
      chk("rst_done", done, 0);
`ifdef SHA_PERF_CNT_EN
      chk("rst_blk_count", blk_count, 0);
      chk("rst_cyc_count", cyc_count, 0);
`endif
   endtask

   // Idle until the model says the sequencer is ready, wiggling ignored junk valids meanwhile.
   task automatic wait_ready();
      while (cyc < ready_at) begin
         bus.blk_valid = ($urandom_range(0, 3) == 0);
         bus.blk_first = 1'($urandom);
         bus.blk_last  = 1'($urandom);
         tick();
      end
      bus.blk_valid = 1'b0;
   endtask

   task automatic send_block(input bit first, input bit last, input bit abc);
      int a;
      wait_ready();
      repeat ($urandom_range(0, 2)) tick();
      for (int i = 0; i < 16; i++) msg[i] = abc ? 32'h0 : $urandom;
      if (abc) begin
         msg[0]  = 32'h61626380;
         msg[15] = 32'h00000018;
      end
      bus.blk_valid = 1'b1;
      bus.blk_first = first;
      bus.blk_last  = last;
      a = cyc + 1;
      if (cyc >= busy_end) busy_start = a;
      busy_end = last ? a + RUN + 3 : BIG;
      nr_start = a;
      ready_at = a + RUN + 2 + (last ? 1 : 0);
      exp_q.push_back('{0, a, int'(first)});
      for (int k = 1; k <= 64; k++) exp_q.push_back('{1, a + k * CPR, k - 1});
      exp_q.push_back('{2, a + RUN + 1, 0});
      exp_blk++;
      if (last) exp_q.push_back('{3, a + RUN + 2, int'(abc)});
      last_accept = a;
      tick();
      bus.blk_valid = 1'b0;
   endtask

   task automatic do_abort(input int at_cyc);
      int x;
      while (cyc < at_cyc) tick();
      bus.abort = 1'b1;
      x = cyc;
      while (exp_q.size() > 0 && (exp_q[exp_q.size()-1].cyc > x ||
             (exp_q[exp_q.size()-1].cyc == x && exp_q[exp_q.size()-1].kind >= 2))) begin
         if (exp_q[exp_q.size()-1].kind == 2) exp_blk--;
         void'(exp_q.pop_back());
      end
      if (busy_end > x + 1) busy_end = x + 1;
      if (ready_at > x + 1) ready_at = x + 1;
      tick();
      bus.abort = 1'b0;
   endtask

   task automatic do_reset_mid(input int at_cyc);
      while (cyc < at_cyc) tick();
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs();
      exp_q.delete();
      nr_start = 0; ready_at = 0; busy_start = 0; busy_end = 0;
      exp_blk = 0; exp_cyc = 0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      bus.blk_valid = 1'b0;
      bus.blk_first = 1'b0;
      bus.blk_last  = 1'b0;
      bus.abort     = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check_reset_outputs();
      rst = 1'b0;
      tick();

      send_block(1'b1, 1'b1, 1'b1);
      send_block(1'b1, 1'b0, 1'b0);
      send_block(1'b0, 1'b1, 1'b0);

      send_block(1'b1, 1'b1, 1'b0);
      do_abort(last_accept + 1 + 30 * CPR + 1);
      send_block(1'b1, 1'b1, 1'b1);

      send_block(1'b1, 1'b1, 1'b0);
      do_reset_mid(last_accept + 1 + 40 * CPR);
      send_block(1'b1, 1'b1, 1'b1);

      for (int m = 0; m < 10; m++) begin
         int nb;
         nb = $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            send_block((b == 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0), b == nb - 1, 1'b0);
         end
         if ($urandom_range(0, 3) == 0) do_abort(last_accept + $urandom_range(0, RUN + 2));
      end

      while (cyc < ready_at + 3) tick();
      chk("queue_drained", exp_q.size(), 0);
`ifdef SHA_PERF_CNT_EN
      chk("blk_count", blk_count, exp_blk);
      chk("cyc_count", cyc_count, exp_cyc);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
